spi_reg_bank: RTL

SPI mode-0 peripheral that receives 16-bit write frames from an external controller and holds the five configuration registers consumed by the PWM stage: output enables, PWM enables and duty cycle. It synchronises the asynchronous SCLK/COPI/nCS pins into the system clock domain, frames each transaction on nCS, and commits a register only after a complete, well-formed frame has been received. Its outputs connect directly to the PWM peripheral's register inputs.

---
 rtl/spi_reg_bank.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-frame receiver feeding the PWM stage's five configuration registers.
// Optional readback of a register on CIPO is compiled in when SPI_READBACK_EN is defined.
module spi_reg_bank #(
    parameter int NUM_REGS   = 5,
    parameter int FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCLK,
    input  logic       COPI,
    input  logic       nCS,
    output logic       CIPO,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       commit
);

    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [6:0]        NUM_REGS_A = 7'(NUM_REGS);

    logic sclk_meta, sclk_sync, sclk_prev;
    logic copi_meta, copi_sync;
    logic ncs_meta, ncs_sync, ncs_prev;

    logic                  sclk_rise, ncs_fall, ncs_rise;
    logic [CNT_W-1:0]      count;
    logic [FRAME_BITS-1:0] shreg;
    logic                  overflow;
    logic [7:0]            regs [NUM_REGS];
    logic                  do_commit;
    logic                  rw;
    logic [6:0]            addr;
    logic [7:0]            data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            copi_meta <= 1'b0;
            copi_sync <= 1'b0;
            ncs_meta  <= 1'b1;
            ncs_sync  <= 1'b1;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            copi_meta <= COPI;
            copi_sync <= copi_meta;
            ncs_meta  <= nCS;
            ncs_sync  <= ncs_meta;
            ncs_prev  <= ncs_sync;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign ncs_fall  = ~ncs_sync & ncs_prev;
    assign ncs_rise  = ncs_sync & ~ncs_prev;

    // A rising nCS already has ncs_sync high, so a coincident SCLK edge is ignored here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else if (ncs_fall) begin
            count    <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else if (!ncs_sync && sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_sync};
            if (count != CNT_SAT) count <= count + 1'b1;
            if (count == CNT_FULL) overflow <= 1'b1;
        end
    end

    assign rw   = shreg[FRAME_BITS-1];
    assign addr = shreg[FRAME_BITS-2 -: 7];
    assign data = shreg[7:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        do_commit = 1'b0;
        if (ncs_rise && count == CNT_FULL && !overflow && rw && addr < NUM_REGS_A)
            do_commit = 1'b1;
    end

    // NOTE: the bank is only a handful of flops, so each entry is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            commit <= 1'b0;
        end else begin
            commit <= do_commit;
            if (do_commit) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (addr == 7'(i)) regs[i] <= data;
            end
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] out_shift;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    assign sclk_fall = ~sclk_sync & sclk_prev;
    // On the 8th rise the last address bit is still in copi_sync, not yet in shreg.
    assign rd_addr   = {shreg[5:0], copi_sync};

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 7'(i)) rd_data = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_shift <= 8'h00;
        end else if (ncs_fall || ncs_rise) begin
            out_shift <= 8'h00;
        end else if (!ncs_sync) begin
            if (sclk_rise && count == CNT_W'(7) && !shreg[6])
                out_shift <= rd_data;
            else if (sclk_fall)
                out_shift <= {out_shift[6:0], 1'b0};
        end
    end

    assign CIPO = out_shift[7];
`else
    assign CIPO = 1'b0;
`endif

endmodule
